// File: rtl/riscv_lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 width codes, FSM state constants
// and the request legality check.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned CNT_W = 8;

  // True when the request must be answered with an error and never reach the bus.
  function automatic logic req_bad(input logic write, input logic [2:0] funct3,
                                   input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (write) illegal = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
    else       illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane steering: store replication/strobes and load extract/extend.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_addr_lo,
  input  logic [XLEN-1:0]   st_wdata,
  output logic [XLEN-1:0]   st_lane_data_c,
  output logic [XLEN/8-1:0] st_strb_c,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_addr_lo,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [XLEN-1:0]   ld_data_c
);

  localparam int unsigned NBYTES = XLEN / 8;

  logic [XLEN-1:0] byte_shift;
  logic [XLEN-1:0] half_shift;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  always_comb begin
    st_lane_data_c = st_wdata;
    st_strb_c      = '1;
    case (st_funct3[1:0])
      2'b00: begin
        st_lane_data_c = {NBYTES{st_wdata[7:0]}};
        st_strb_c      = NBYTES'(1) << st_addr_lo;
      end
      2'b01: begin
        st_lane_data_c = {(NBYTES/2){st_wdata[15:0]}};
        st_strb_c      = st_addr_lo[1] ? NBYTES'(4'b1100) : NBYTES'(4'b0011);
      end
      default: ;
    endcase
  end

  assign byte_shift = ld_rdata >> {ld_addr_lo, 3'b000};
  assign half_shift = ld_rdata >> {ld_addr_lo[1], 4'b0000};
  assign ld_byte    = byte_shift[7:0];
  assign ld_half    = half_shift[15:0];

  always_comb begin
    ld_data_c = ld_rdata;
    case (ld_funct3)
      F3_B:    ld_data_c = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_c = {{(XLEN-8){1'b0}}, ld_byte};
      F3_H:    ld_data_c = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_HU:   ld_data_c = {{(XLEN-16){1'b0}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one request at a time, req/ack data bus with timeout,
// registered response with extended load data or a single error flag.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_error,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [XLEN-1:0]   bus_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       addr_lo_q, addr_lo_d;

  logic              req_ready_d, resp_valid_d, resp_error_d;
  logic [XLEN-1:0]   resp_rdata_d;
  logic              bus_req_d, bus_we_d;
  logic [XLEN-1:0]   bus_addr_d, bus_wdata_d;
  logic [XLEN/8-1:0] bus_wstrb_d;

  logic [XLEN-1:0]   st_lane_data_c;
  logic [XLEN/8-1:0] st_strb_c;
  logic [XLEN-1:0]   ld_data_c;

  riscv_lsu_align #(.XLEN(XLEN)) u_align (
    .st_funct3      (req_funct3),
    .st_addr_lo     (req_addr[1:0]),
    .st_wdata       (req_wdata),
    .st_lane_data_c (st_lane_data_c),
    .st_strb_c      (st_strb_c),
    .ld_funct3      (f3_q),
    .ld_addr_lo     (addr_lo_q),
    .ld_rdata       (bus_rdata),
    .ld_data_c      (ld_data_c)
  );

  // Next state and next registered outputs; bus outputs are only non-zero while in BUS.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    addr_lo_d    = addr_lo_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = '0;
    bus_req_d    = 1'b0;
    bus_we_d     = 1'b0;
    bus_addr_d   = '0;
    bus_wdata_d  = '0;
    bus_wstrb_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          f3_d      = req_funct3;
          addr_lo_d = req_addr[1:0];
          if (req_bad(req_write, req_funct3, req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d     = ST_BUS;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = req_write;
            bus_addr_d  = {req_addr[XLEN-1:2], 2'b00};
            bus_wdata_d = req_write ? st_lane_data_c : '0;
            bus_wstrb_d = req_write ? st_strb_c : '0;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_BUS: begin
        cnt_d       = cnt_q + CNT_W'(1);
        bus_req_d   = 1'b1;
        bus_we_d    = bus_we;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;
        bus_wstrb_d = bus_wstrb;
        // Error beats ack; ack beats a timeout expiring in the same cycle.
        if (bus_err || bus_ack || (cnt_q == TO_LAST)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          bus_req_d    = 1'b0;
          bus_we_d     = 1'b0;
          bus_addr_d   = '0;
          bus_wdata_d  = '0;
          bus_wstrb_d  = '0;
          if (bus_err || !bus_ack) resp_error_d = 1'b1;
          else if (!bus_we)        resp_rdata_d = ld_data_c;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      addr_lo_q  <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      addr_lo_q  <= addr_lo_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_error <= resp_error_d;
      resp_rdata <= resp_rdata_d;
      bus_req    <= bus_req_d;
      bus_we     <= bus_we_d;
      bus_addr   <= bus_addr_d;
      bus_wdata  <= bus_wdata_d;
      bus_wstrb  <= bus_wstrb_d;
    end
  end

endmodule
